// File: rtl/vault_escape_pkg.sv
// Shared types and default keys for the vault escape puzzle.
// Provides the FSM state enum, key constants and a plate lookup helper.
package vault_escape_pkg;

  typedef enum logic [2:0] {
    S_CODE,
    S_SWITCH,
    S_DIR,
    S_PLATE,
    S_OPEN,
    S_ESCAPE,
    S_ALARM
  } state_t;

  localparam logic [3:0] KEY_SWITCH = 4'b1010;
  localparam logic [2:0] KEY_DIR    = 3'b010;
  localparam logic [7:0] PLATE0     = 8'hAA;
  localparam logic [7:0] PLATE1     = 8'hCC;
  localparam logic [7:0] PLATE2     = 8'hF0;
  localparam logic [1:0] TL_MAX     = 2'd3;

  function automatic logic [7:0] plate_at(
    input logic [1:0] i,
    input logic [7:0] p0,
    input logic [7:0] p1,
    input logic [7:0] p2
  );
    logic [7:0] r;
    case (i)
      2'd0:    r = p0;
      2'd1:    r = p1;
      2'd2:    r = p2;
      default: r = p0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vault_escape_plate_sequencer.sv
// Three-step pressure-plate checker: tracks idx, tolerates held plates.
// Ports: clk, reset(async low), en, check4, plate_in -> done, error.
module plate_sequencer
  import vault_escape_pkg::*;
#(
  parameter logic [7:0] P0 = vault_escape_pkg::PLATE0,
  parameter logic [7:0] P1 = vault_escape_pkg::PLATE1,
  parameter logic [7:0] P2 = vault_escape_pkg::PLATE2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       check4,
  input  logic [7:0] plate_in,
  output logic       done,
  output logic       error
);

  logic [1:0] idx;
  logic [7:0] cur;
  logic [7:0] prev;
  logic       hit;
  logic       rpt;

  always_comb begin
    cur  = plate_at(idx, P0, P1, P2);
    prev = plate_at(idx - 2'd1, P0, P1, P2);
    hit  = check4 && (plate_in == cur);
    // Re-presenting the plate just accepted is a hold, not a fault.
    rpt  = check4 && (idx != 2'd0)
        && (plate_in == prev);
    done  = en && hit && (idx == 2'd2);
    error = en && check4 && !hit && !rpt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
    end else if (en && hit) begin
      idx <= (idx == 2'd2) ? 2'd0
           : idx + 2'd1;
    end
  end

endmodule

// File: rtl/vault_escape_top_module.sv
// Vault escape sequencer: code, switch, dir, plates, then time lock.
// Ports: clk, reset(async low), stage inputs -> registered status outputs.
module vault_escape_top_module
  import vault_escape_pkg::*;
#(
  parameter logic [3:0] KEY_SWITCH = vault_escape_pkg::KEY_SWITCH,
  parameter logic [2:0] KEY_DIR    = vault_escape_pkg::KEY_DIR,
  parameter logic [7:0] PLATE0     = vault_escape_pkg::PLATE0,
  parameter logic [7:0] PLATE1     = vault_escape_pkg::PLATE1,
  parameter logic [7:0] PLATE2     = vault_escape_pkg::PLATE2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_in,
  input  logic       check2,
  input  logic [3:0] switch_in,
  input  logic       valid3,
  input  logic [2:0] dir_in,
  input  logic       check4,
  input  logic [7:0] plate_in,
  output logic       all_done,
  output logic       vault,
  output logic       waltescape,
  output logic       epwave,
  output logic [1:0] time_lock_out,
  output logic       alarm
);

  state_t     state;
  logic       pl_en;
  logic       pl_done;
  logic       pl_err;
  logic [1:0] tl_nxt;

  assign pl_en  = (state == S_PLATE);
  assign tl_nxt = time_lock_out + 2'd1;

  plate_sequencer #(
    .P0(PLATE0),
    .P1(PLATE1),
    .P2(PLATE2)
  ) u_plates (
    .clk      (clk),
    .reset    (reset),
    .en       (pl_en),
    .check4   (check4),
    .plate_in (plate_in),
    .done     (pl_done),
    .error    (pl_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_CODE;
      all_done      <= 1'b0;
      vault         <= 1'b0;
      waltescape    <= 1'b0;
      epwave        <= 1'b0;
      time_lock_out <= 2'd0;
      alarm         <= 1'b0;
    end else begin
      unique case (state)
        S_CODE: begin
          if (code_in) state <= S_SWITCH;
        end
        S_SWITCH: begin
          if (check2) begin
            if (switch_in == KEY_SWITCH) begin
              state <= S_DIR;
            end else begin
              state <= S_ALARM;
              alarm <= 1'b1;
            end
          end
        end
        S_DIR: begin
          if (valid3) begin
            if (dir_in == KEY_DIR) begin
              state <= S_PLATE;
            end else begin
              state <= S_ALARM;
              alarm <= 1'b1;
            end
          end
        end
        S_PLATE: begin
          if (pl_err) begin
            state <= S_ALARM;
            alarm <= 1'b1;
          end else if (pl_done) begin
            state         <= S_OPEN;
            all_done      <= 1'b1;
            vault         <= 1'b1;
            time_lock_out <= 2'd0;
          end
        end
        S_OPEN: begin
          time_lock_out <= tl_nxt;
          if (tl_nxt == TL_MAX) begin
            state      <= S_ESCAPE;
            vault      <= 1'b0;
            waltescape <= 1'b1;
            epwave     <= 1'b0;
          end
        end
        S_ESCAPE: begin
          time_lock_out <= TL_MAX;
          epwave        <= ~epwave;
        end
        S_ALARM: begin
          alarm <= 1'b1;
        end
        default: begin
          state         <= S_ALARM;
          all_done      <= 1'b0;
          vault         <= 1'b0;
          waltescape    <= 1'b0;
          epwave        <= 1'b0;
          time_lock_out <= 2'd0;
          alarm         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vault_escape_top_module.sv
// Self-checking bench for vault_escape_top_module.
// Directed scenarios plus random stimulus against a progress-count model.
module tb_vault_escape_top_module;

  logic       clk;
  logic       reset;
  logic       code_in;
  logic       check2;
  logic [3:0] switch_in;
  logic       valid3;
  logic [2:0] dir_in;
  logic       check4;
  logic [7:0] plate_in;
  logic       all_done;
  logic       vault;
  logic       waltescape;
  logic       epwave;
  logic [1:0] time_lock_out;
  logic       alarm;

  int checks;
  int failures;

  // Model: number of keys accepted (0..6), alarm latch, cycles since open.
  int m_passed;
  bit m_alarm;
  int m_open;
  logic [7:0] plates [3];

  typedef struct packed {
    logic       c;
    logic       c2;
    logic [3:0] sw;
    logic       v3;
    logic [2:0] d;
    logic       c4;
    logic [7:0] p;
  } stim_t;

  stim_t q[$];

  vault_escape_top_module dut (
    .clk           (clk),
    .reset         (reset),
    .code_in       (code_in),
    .check2        (check2),
    .switch_in     (switch_in),
    .valid3        (valid3),
    .dir_in        (dir_in),
    .check4        (check4),
    .plate_in      (plate_in),
    .all_done      (all_done),
    .vault         (vault),
    .waltescape    (waltescape),
    .epwave        (epwave),
    .time_lock_out (time_lock_out),
    .alarm         (alarm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(
    input logic c, input logic c2, input logic [3:0] sw,
    input logic v3, input logic [2:0] d,
    input logic c4, input logic [7:0] p);
    stim_t s;
    s.c = c; s.c2 = c2; s.sw = sw;
    s.v3 = v3; s.d = d; s.c4 = c4; s.p = p;
    return s;
  endfunction

  function automatic logic [6:0] obs_vec();
    return {all_done, vault, waltescape, epwave,
            time_lock_out, alarm};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic done;
    logic [1:0] tl;
    done = (m_passed == 6) && !m_alarm;
    tl = !done ? 2'd0 : (m_open >= 3) ? 2'd3 : 2'(m_open);
    return {done,
            done && (m_open < 3),
            done && (m_open >= 3),
            done && (m_open >= 3) && ((m_open - 3) % 2 == 1),
            tl,
            m_alarm};
  endfunction

  task automatic apply(input stim_t s);
    code_in = s.c; check2 = s.c2; switch_in = s.sw;
    valid3 = s.v3; dir_in = s.d; check4 = s.c4;
    plate_in = s.p;
  endtask

  task automatic model_step();
    int k;
    if (m_alarm) return;
    if (m_passed == 0) begin
      if (code_in) m_passed = 1;
    end else if (m_passed == 1) begin
      if (check2) begin
        if (switch_in == 4'b1010) m_passed = 2;
        else m_alarm = 1;
      end
    end else if (m_passed == 2) begin
      if (valid3) begin
        if (dir_in == 3'b010) m_passed = 3;
        else m_alarm = 1;
      end
    end else if (m_passed < 6) begin
      k = m_passed - 3;
      if (check4) begin
        if (plate_in == plates[k]) m_passed++;
        else if (k > 0 && plate_in == plates[k-1]) m_passed = m_passed;
        else m_alarm = 1;
      end
    end else if (m_open < 1000) begin
      m_open++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    m_passed = 0; m_alarm = 0; m_open = 0;
    apply(st(0, 0, 0, 0, 0, 0, 0));
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic add_happy(input int upto);
    stim_t h [12];
    h[0]  = st(1, 0, 0, 0, 0, 0, 0);
    h[1]  = st(1, 0, 0, 0, 0, 0, 0);
    h[2]  = st(0, 1, 4'b1010, 0, 0, 0, 0);
    h[3]  = st(0, 1, 4'b1010, 0, 0, 0, 0);
    h[4]  = st(0, 0, 0, 1, 3'b010, 0, 0);
    h[5]  = st(0, 0, 0, 1, 3'b010, 0, 0);
    h[6]  = st(0, 0, 0, 0, 0, 1, 8'hAA);
    h[7]  = st(0, 0, 0, 0, 0, 1, 8'hAA);
    h[8]  = st(0, 0, 0, 0, 0, 1, 8'hCC);
    h[9]  = st(0, 0, 0, 0, 0, 1, 8'hCC);
    h[10] = st(0, 0, 0, 0, 0, 1, 8'hF0);
    h[11] = st(0, 0, 0, 0, 0, 1, 8'hF0);
    for (int i = 0; i < upto; i++) q.push_back(h[i]);
  endtask

  task automatic test_reset();
    hard_reset();
    if (obs_vec() !== 7'd0) begin
      failures++;
      $display("FAIL reset outputs got=%b exp=%b", obs_vec(), 7'd0);
    end
    checks++;
  endtask

  task automatic test_happy();
    logic ep0;
    hard_reset();
    q.delete();
    add_happy(12);
    for (int i = 0; i < 6; i++) q.push_back(st(0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL happy[%0d] got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      checks++;
      if (i == 10) begin
        if ({all_done, vault, time_lock_out} !== 4'b1100) begin
          failures++;
          $display("FAIL happy_open got=%b exp=1100",
                   {all_done, vault, time_lock_out});
        end
        checks++;
      end
      if (i == 13) begin
        if ({waltescape, time_lock_out, alarm} !== 4'b1110) begin
          failures++;
          $display("FAIL happy_escape got=%b exp=1110",
                   {waltescape, time_lock_out, alarm});
        end
        checks++;
      end
    end
    ep0 = epwave;
    tick();
    if (epwave === ep0) begin
      failures++;
      $display("FAIL happy_epwave got=%b exp=%b", epwave, ~ep0);
    end
    checks++;
  endtask

  task automatic test_wrong_switch();
    hard_reset();
    q.delete();
    q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    q.push_back(st(0, 1, 4'b0101, 0, 0, 0, 0));
    q.push_back(st(0, 1, 4'b1010, 0, 0, 0, 0));
    q.push_back(st(0, 0, 0, 1, 3'b010, 0, 0));
    q.push_back(st(0, 0, 0, 0, 0, 1, 8'hAA));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrong_switch[%0d] got=%b exp=%b",
                 i, obs_vec(), exp_vec());
      end
      checks++;
      if (i >= 1 && alarm !== 1'b1) begin
        failures++;
        $display("FAIL wrong_switch_alarm[%0d] got=%b exp=1", i, alarm);
      end
      checks++;
    end
  endtask

  task automatic test_wrong_order();
    hard_reset();
    q.delete();
    add_happy(7);
    q.push_back(st(0, 0, 0, 0, 0, 1, 8'hF0));
    q.push_back(st(0, 0, 0, 0, 0, 1, 8'hCC));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrong_order[%0d] got=%b exp=%b",
                 i, obs_vec(), exp_vec());
      end
      checks++;
    end
    if ({alarm, all_done} !== 2'b10) begin
      failures++;
      $display("FAIL wrong_order_final got=%b exp=10", {alarm, all_done});
    end
    checks++;
  endtask

  task automatic test_stray();
    hard_reset();
    q.delete();
    q.push_back(st(0, 0, 0, 1, 3'b111, 0, 0));
    q.push_back(st(0, 1, 4'b0000, 1, 3'b001, 1, 8'h12));
    q.push_back(st(1, 0, 0, 0, 0, 1, 8'h00));
    q.push_back(st(0, 0, 0, 1, 3'b000, 1, 8'h00));
    q.push_back(st(0, 1, 4'b1010, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stray[%0d] got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      checks++;
      if (i < 2 && alarm !== 1'b0) begin
        failures++;
        $display("FAIL stray_alarm[%0d] got=%b exp=0", i, alarm);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    hard_reset();
    q.delete();
    add_happy(10);
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_pre[%0d] got=%b exp=%b",
                 i, obs_vec(), exp_vec());
      end
      checks++;
    end
    // Force outputs nonzero first so the async clear is observable.
    apply(st(0, 0, 0, 0, 0, 1, 8'hF0));
    tick();
    reset = 1'b0;
    m_passed = 0; m_alarm = 0; m_open = 0;
    #1;
    if (obs_vec() !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs_vec(), 7'd0);
    end
    checks++;
    apply(st(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    add_happy(12);
    for (int i = 0; i < 4; i++) q.push_back(st(0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_post[%0d] got=%b exp=%b",
                 i, obs_vec(), exp_vec());
      end
      checks++;
    end
    if (waltescape !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_escape got=%b exp=1", waltescape);
    end
    checks++;
  endtask

  task automatic test_gaps();
    hard_reset();
    q.delete();
    add_happy(7);
    for (int i = 0; i < 5; i++) q.push_back(st(0, 0, 0, 0, 0, 0, 8'h55));
    q.push_back(st(0, 0, 0, 0, 0, 1, 8'hCC));
    q.push_back(st(0, 0, 0, 0, 0, 0, 0));
    q.push_back(st(0, 0, 0, 0, 0, 1, 8'hF0));
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL gaps[%0d] got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    if ({all_done, vault, alarm} !== 3'b110) begin
      failures++;
      $display("FAIL gaps_final got=%b exp=110", {all_done, vault, alarm});
    end
    checks++;
  endtask

  task automatic test_random();
    stim_t s;
    for (int ep = 0; ep < 40; ep++) begin
      hard_reset();
      for (int c = 0; c < 40; c++) begin
        s.c  = ($urandom_range(0, 2) == 0);
        s.c2 = ($urandom_range(0, 3) == 0);
        s.sw = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b1010;
        s.v3 = ($urandom_range(0, 3) == 0);
        s.d  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010;
        s.c4 = ($urandom_range(0, 1) == 0);
        s.p  = ($urandom_range(0, 7) == 0) ? 8'($urandom)
             : plates[$urandom_range(0, 2)];
        apply(s);
        tick();
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL random[%0d.%0d] got=%b exp=%b",
                   ep, c, obs_vec(), exp_vec());
        end
        checks++;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    plates[0] = 8'hAA;
    plates[1] = 8'hCC;
    plates[2] = 8'hF0;
    reset = 1'b0;
    apply(st(0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_happy();
    test_wrong_switch();
    test_wrong_order();
    test_stray();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vault_escape_top_module.md
# vault_escape_top_module

Four-stage "vault escape" puzzle sequencer: a code strobe, a switch pattern, a direction, and a three-step pressure-plate sequence are validated in order. On completion the vault opens, a 2-bit time lock counts out, and the escape flag plus a heartbeat toggle assert. Any wrong entry latches a sticky alarm. It is the top of the puzzle design; all inputs come from synchronous board-level logic.

## Interface
- `KEY_SWITCH`, default 4'b1010: required switch pattern.
- `KEY_DIR`, default 3'b010: required direction.
- `PLATE0/1/2`, defaults 8'hAA, 8'hCC, 8'hF0: required plate sequence.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `code_in` in 1: stage-1 code strobe.
- `check2` in 1: stage-2 qualifier for `switch_in`.
- `switch_in` in 4: stage-2 data.
- `valid3` in 1: stage-3 qualifier for `dir_in`.
- `dir_in` in 3: stage-3 data.
- `check4` in 1: stage-4 qualifier for `plate_in`.
- `plate_in` in 8: stage-4 data.
- `all_done` out 1: all four stages passed (level, sticky).
- `vault` out 1: vault open, time lock running.
- `waltescape` out 1: time lock expired, escape granted.
- `epwave` out 1: heartbeat, toggles every cycle while `waltescape`=1.
- `time_lock_out` out 2: time-lock counter.
- `alarm` out 1: sticky wrong-entry alarm.

## Operation
- States: S_CODE, S_SWITCH, S_DIR, S_PLATE, S_OPEN, S_ESCAPE, S_ALARM.
- S_CODE: `code_in`=1 -> S_SWITCH. Otherwise hold.
- S_SWITCH: `check2`=1 and `switch_in`==KEY_SWITCH -> S_DIR; `check2`=1 with mismatch -> S_ALARM; `check2`=0 -> hold.
- S_DIR: `valid3`=1 and `dir_in`==KEY_DIR -> S_PLATE; `valid3`=1 with mismatch -> S_ALARM; else hold.
- S_PLATE: 2-bit index idx (0..2) plus "last matched" flag.
  - `check4`=1 and `plate_in`==PLATE[idx]: advance idx.
  - idx==2 match -> S_OPEN.
  - `check4`=1 and `plate_in`==PLATE[idx-1] (idx>0): hold, no error. This allows plates held several cycles.
  - Any other value with `check4`=1 -> S_ALARM.
  - `check4`=0: hold idx.
- Qualifiers for stages other than the current one are ignored (no alarm).
- S_OPEN: `time_lock_out` increments by 1 each cycle from 0. When it reaches 3 -> S_ESCAPE.
- S_ESCAPE: terminal. `time_lock_out` saturates at 3.
- S_ALARM: terminal until reset. All other outputs are 0.
- Output decode, all from registers:
  - `all_done`=1 in S_OPEN and S_ESCAPE.
  - `vault`=1 in S_OPEN only.
  - `waltescape`=1 in S_ESCAPE.
  - `epwave`: 0 on entry to S_ESCAPE, inverts every cycle thereafter; 0 in all other states.
  - `alarm`=1 in S_ALARM.

## Timing
- Reset value of every output: 0. State is S_CODE, idx=0, counter=0.
- All inputs are sampled on the rising edge. A state change is visible on outputs the same edge it is registered (Moore, registered, 1-cycle latency from the sampling edge).
- Completion to escape: `all_done`/`vault` rise on the edge accepting PLATE2. Then `time_lock_out` = 0,1,2 on successive edges, and 3 with `waltescape`=1 on the third edge after.
- Simultaneous qualifiers: only the current stage's qualifier is evaluated.
- Async reset mid-operation returns to S_CODE immediately, regardless of clock.

## Structure
- Shared package `vault_escape_pkg`: state enum, default key constants (KEY_SWITCH, KEY_DIR, PLATE0..2), TL_MAX=2'd3.
- One sub-module `plate_sequencer`:
  - Inputs: clk, reset, en, check4, plate_in.
  - Outputs: done, error.
  - Contains idx and the hold logic.
- Top contains the FSM, time-lock counter and heartbeat.

## Test plan
- Happy path, 10 ns clock. Release reset, then apply the following at 20 ns intervals:
  - `code_in`=1; then `check2`=1 with `switch_in`=4'b1010; then `valid3`=1 with `dir_in`=3'b010.
  - `check4`=1 with `plate_in` AA, CC, F0, each held 2 cycles.
  - Required: `all_done`=1, `vault`=1, then `time_lock_out` 1,2,3, `waltescape`=1, `alarm`=0.
  - `epwave` must differ across one further clock.
- Wrong switch: `check2`=1 with `switch_in`=4'b0101 in S_SWITCH -> `alarm`=1 next edge and stays 1. Further correct inputs have no effect.
- Wrong plate order: after AA, present F0 with `check4`=1 -> `alarm`=1, `all_done`=0.
- Stray qualifier: `valid3`=1 with a bad `dir_in` while in S_CODE -> no alarm, still waiting for `code_in`.
- Reset mid-sequence: deassert `reset` (drive 0) asynchronously in S_PLATE after CC -> all outputs 0 immediately. A fresh full sequence then succeeds.
- Plate gaps: AA, then `check4`=0 for 5 cycles, then CC, then F0 -> completes without alarm.
